// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM state encoding and opcode constants for the fetch unit
// and the control unit that decodes its registered opcode.
package fetch_unit_pkg;

  localparam int PC_W     = 4;
  localparam int INSTR_W  = 8;
  localparam int OPCODE_W = 4;
  localparam int IMM_W    = INSTR_W - OPCODE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: load a jump target, increment with natural modulo wrap,
// or hold. Resets asynchronously to address 0.
module pc_counter
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE -> FETCH -> EXEC) with instruction register.
// Memory handshake: imem_req/imem_addr are held from registered state until
// the first cycle imem_ack is high; imem_data is captured on that cycle only.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                jmp_sel,
  input  logic                stall,
  output logic [OPCODE_W-1:0] opcode,
  output logic [IMM_W-1:0]    imm,
  output logic [PC_W-1:0]     pc,
  output logic                instr_valid,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_EXEC  = ST_EXEC;

  logic [1:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic                run_q, run_d;
  logic                pc_load;
  logic                pc_inc;

  // run_q spends the first clock after reset release in IDLE so the first
  // request appears on the second rising edge.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    run_d    = 1'b1;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          opcode_d = imem_data[INSTR_W-1:IMM_W];
          imm_d    = imem_data[IMM_W-1:0];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_load = jmp_sel;
          pc_inc  = !jmp_sel;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      imm_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      run_q    <= run_d;
    end
  end

  pc_counter u_pc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (imm_q),
    .pc       (pc)
  );

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == S_EXEC);
  assign opcode      = opcode_q;
  assign imm         = imm_q;
  assign fsm_state   = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request; held high until acknowledged.
REQ-005 imem_addr  output  4  read address; equals pc while imem_req is high.
REQ-006 imem_ack  input  1  memory has imem_data valid this cycle.
REQ-007 imem_data  input  8  instruction word: [7:4] opcode, [3:0] immediate/jump target.
REQ-008 jmp_sel  input  1  taken-jump decision from the control unit for the current instruction.
REQ-009 stall  input  1  holds the current instruction in execute.
REQ-010 opcode  output  4  registered opcode feeding the control unit.
REQ-011 imm  output  4  registered immediate feeding datapath and jump target.
REQ-012 pc  output  4  program counter of the instruction being fetched or executed.
REQ-013 instr_valid  output  1  opcode/imm hold a valid instruction in execute.

Function
REQ-014 The FSM SHALL have three states: IDLE, FETCH, EXEC.
REQ-015 IDLE: imem_req=0, instr_valid=0; unconditional transition to FETCH next cycle.
REQ-016 FETCH: imem_req=1, imem_addr=pc; stay while imem_ack=0; on imem_ack=1 latch imem_data[7:4] into opcode and imem_data[3:0] into imm, go to EXEC.
REQ-017 imem_ack SHALL be ignored in IDLE and EXEC; imem_data SHALL be sampled only in FETCH with imem_ack=1.
REQ-018 EXEC: instr_valid=1, imem_req=0; opcode/imm stable for the whole EXEC residency.
REQ-019 EXEC with stall=1: remain in EXEC, pc/opcode/imm unchanged.
REQ-020 EXEC with stall=0 (commit): pc <= imm if jmp_sel=1, else pc+1; go to FETCH.
REQ-021 pc+1 SHALL wrap modulo 16 (15 -> 0); no overflow flag.
REQ-022 jmp_sel SHALL be ignored outside EXEC and on stalled EXEC cycles.
REQ-023 Jump to own address (imm == pc) SHALL refetch the same address; no special casing.
REQ-024 Minimum throughput: one instruction per 2 cycles (FETCH with same-cycle ack, then EXEC); each memory wait cycle adds one.
REQ-025 imem_req and instr_valid SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-026 On rst_n=0, immediately: state=IDLE, pc=0, opcode=0, imm=0, imem_req=0, imem_addr=0, instr_valid=0.
REQ-027 Reset asserted mid-FETCH SHALL drop imem_req asynchronously; a late imem_ack SHALL be ignored.
REQ-028 After rst_n deasserts, first imem_req SHALL rise on the second rising clk edge (IDLE, then FETCH).

Structure
REQ-029 A shared package SHALL hold PC_W=4, INSTR_W=8, OPCODE_W=4, the FSM state enum, and opcode constants shared with the control unit.
REQ-030 PC update SHALL be a sub-module pc_counter (load, increment, hold, async reset to 0); the FSM and instruction register stay in fetch_unit.

Verification
REQ-031 Reset release, ack tied high, ROM[0]=0x15, jmp_sel=0 -> imem_req rises cycle 2, opcode=1/imm=5 with instr_valid cycle 3, pc=1 at next FETCH.
REQ-032 ack delayed 3 cycles at pc=2 -> imem_req/imem_addr=2 held 4 cycles, opcode/imm unchanged until ack cycle.
REQ-033 EXEC of 0x39 with jmp_sel=1 -> next imem_addr=9; with jmp_sel=0 -> next imem_addr=pc+1.
REQ-034 pc=15, no jump -> next imem_addr=0.
REQ-035 stall=1 for 2 EXEC cycles with jmp_sel toggling -> instr_valid high 3 cycles, pc unchanged until commit, only commit-cycle jmp_sel applies.
REQ-036 rst_n pulsed low during FETCH at pc=6 with ack arriving next cycle -> all outputs 0 immediately, ack ignored, restart fetches address 0.
